carregador_matriz: RTL and testbench

Sequential matrix loader that sits directly upstream of `oposicao_matriz` and the other element-wise matrix operators. It accepts signed 8-bit elements one per handshake beat, in row-major order, and packs them into the 200-bit `matrix_A` bus those operators consume. It asserts `done` once the number of elements implied by `matrix_size` has been received. Lanes beyond the active size are driven to zero, so downstream operators see a clean operand.

---
 rtl/matriz_pkg.sv | 33 +++
 rtl/contador_elementos.sv | 26 ++
 rtl/carregador_matriz.sv | 104 ++++++++++
 tb/tb_carregador_matriz.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/matriz_pkg.sv
// Shared definitions for the element-wise matrix operators: widths, size codes,
// size-to-element-count mapping and the loader state encoding.
package matriz_pkg;

  localparam int ELEM_W    = 8;
  localparam int MAX_ELEMS = 25;

  typedef enum logic [1:0] {
    TAM_2X2 = 2'b00,
    TAM_3X3 = 2'b01,
    TAM_4X4 = 2'b10,
    TAM_5X5 = 2'b11
  } tam_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_DONE = 2'b10
  } estado_t;

  // (code + 2)^2 elements for a square matrix
  function automatic logic [4:0] tam_para_n(input logic [1:0] code);
    logic [4:0] n;
    case (code)
      TAM_2X2: n = 5'd4;
      TAM_3X3: n = 5'd9;
      TAM_4X4: n = 5'd16;
      default: n = 5'd25;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/contador_elementos.sv
// Element index counter: synchronous clear, enable, and a terminal flag that
// fires on the enabled step that reaches the limit.
module contador_elementos (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [4:0] limite,
  output logic [4:0] count,
  output logic       terminal
);

  logic [4:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_reg <= 5'd0;
    end else if (en) begin
      count_reg <= count_reg + 5'd1;
    end
  end

  assign count    = count_reg;
  assign terminal = en && ((count_reg + 5'd1) == limite);

endmodule

// File: rtl/carregador_matriz.sv
// Sequential row-major loader packing signed elements into the 200-bit matrix_A bus.
// Optional macro CARREGADOR_MATRIZ_HAS_MIN_EN builds the sticky -128 detector.
module carregador_matriz
  import matriz_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [1:0]                    matrix_size,
  input  logic                          in_valid,
  input  logic [ELEM_W-1:0]             in_data,
  output logic                          in_ready,
  output logic [ELEM_W*MAX_ELEMS-1:0]   matrix_A,
  output logic                          busy,
  output logic                          done,
  output logic [4:0]                    elem_count,
  output logic                          has_min
);

  estado_t    state_reg, state_next;
  logic [4:0] n_reg;
  logic       busy_reg, done_reg;
  logic       accept_start;
  logic       beat;
  logic       terminal;

  assign in_ready     = (state_reg == ST_LOAD);
  assign accept_start = (state_reg == ST_IDLE) && start;
  assign beat         = in_valid && in_ready;

  contador_elementos u_contador (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept_start),
    .en       (beat),
    .limite   (n_reg),
    .count    (elem_count),
    .terminal (terminal)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start)    state_next = ST_LOAD;
      ST_LOAD: if (terminal) state_next = ST_DONE;
      ST_DONE:               state_next = ST_IDLE;
      default:               state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      n_reg     <= 5'd0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != ST_IDLE);
      done_reg  <= (state_next == ST_DONE);
      if (accept_start) begin
        n_reg <= tam_para_n(matrix_size);
      end
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;

  // One register per lane; lanes at or above N are never addressed, so stay zero.
  generate
    for (genvar gi = 0; gi < MAX_ELEMS; gi++) begin : g_lane
      logic [ELEM_W-1:0] lane_reg;

      always_ff @(posedge clk) begin
        if (reset || accept_start) begin
          lane_reg <= '0;
        end else if (beat && (elem_count == 5'(gi))) begin
          lane_reg <= in_data;
        end
      end

      assign matrix_A[gi*ELEM_W +: ELEM_W] = lane_reg;
    end
  endgenerate

`ifdef CARREGADOR_MATRIZ_HAS_MIN_EN
  logic has_min_reg;

  // -128 has no positive counterpart, so downstream negation would overflow
  always_ff @(posedge clk) begin
    if (reset || accept_start) begin
      has_min_reg <= 1'b0;
    end else if (beat && (in_data == 8'h80)) begin
      has_min_reg <= 1'b1;
    end
  end

  assign has_min = has_min_reg;
`else
  assign has_min = 1'b0;
`endif

endmodule

// File: tb/tb_carregador_matriz.sv
// Scoreboard bench for carregador_matriz: the driver queues expected results per load,
// a negedge monitor checks them whenever done pulses.
module tb_carregador_matriz;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   matrix_size;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [199:0] matrix_A;
  logic         busy;
  logic         done;
  logic [4:0]   elem_count;
  logic         has_min;

  typedef struct {
    logic [199:0] mat;
    int           cnt;
    int           lat;
    logic         min;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         start_cyc = 0;
  logic [7:0] vec [25];

`ifdef CARREGADOR_MATRIZ_HAS_MIN_EN
  localparam logic MIN_EXP = 1'b1;
`else
  localparam logic MIN_EXP = 1'b0;
`endif

  carregador_matriz dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .matrix_size (matrix_size),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .matrix_A    (matrix_A),
    .busy        (busy),
    .done        (done),
    .elem_count  (elem_count),
    .has_min     (has_min)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [199:0] got, input logic [199:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Monitor: one line per completed load
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done got=1 want=0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        $display("load done: cnt=%0d lat=%0d mat=%0h", elem_count, cyc - start_cyc, matrix_A);
        chk("done_mat", matrix_A, e.mat);
        chk("done_cnt", 200'(elem_count), 200'(e.cnt));
        chk("done_lat", 200'(cyc - start_cyc), 200'(e.lat));
        chk("done_min", 200'(has_min), 200'(e.min));
        chk("done_ready", 200'(in_ready), 200'(0));
        chk("done_busy", 200'(busy), 200'(1));
      end
    end
  end

  task automatic run_load(input logic [1:0] sz, input int n, input bit stall, input bit poke,
                          input logic [199:0] exp_mat, input int exp_lat, input logic exp_min);
    exp_t e;
    @(negedge clk);
    e.mat = exp_mat; e.cnt = n; e.lat = exp_lat; e.min = exp_min;
    sb.push_back(e);
    start       = 1'b1;
    matrix_size = sz;
    start_cyc   = cyc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start       = poke && (i == 2);
      matrix_size = ~sz;
      if (i == 0) chk("min_clear", 200'(has_min), 200'(0));
      else if (vec[i-1] == 8'h80) chk("min_next", 200'(has_min), 200'(exp_min));
      if (stall && i > 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = vec[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    for (int k = 0; k < 60 && sb.size() > 0; k++) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL done_timeout got=pending%0d want=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    chk("hold_mat", matrix_A, exp_mat);
    chk("hold_cnt", 200'(elem_count), 200'(n));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int errs;
    logic signed [7:0] b;
    reset = 1'b1; start = 1'b0; matrix_size = 2'b00; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_mat", matrix_A, '0);
    chk("rst_ready", 200'(in_ready), 200'(0));
    chk("rst_busy", 200'(busy), 200'(0));
    chk("rst_done", 200'(done), 200'(0));
    chk("rst_cnt", 200'(elem_count), 200'(0));
    chk("rst_min", 200'(has_min), 200'(0));
    reset = 1'b0;

    // 2x2 basic
    vec[0] = 8'd10; vec[1] = 8'hEC; vec[2] = 8'd30; vec[3] = 8'hD8;
    run_load(2'b00, 4, 1'b0, 1'b0, 200'hD81EEC0A, 5, 1'b0);

    // 3x3 with stalls between every beat
    for (int i = 0; i < 9; i++) vec[i] = 8'(5 * i);
    run_load(2'b01, 9, 1'b1, 1'b0, 200'h28231E19140F0A0500, 18, 1'b0);

    // 5x5 negatives, then downstream negation must give 0..24
    for (int i = 0; i < 25; i++) vec[i] = 8'(-i);
    run_load(2'b11, 25, 1'b0, 1'b0,
             200'hE8E9EAEBECEDEEEFF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF00, 26, 1'b0);
    errs = 0;
    for (int i = 0; i < 25; i++) begin
      b = matrix_A[i*8 +: 8];
      if (8'(-b) != 8'(i)) errs++;
    end
    chk("oposicao_lanes", 200'(errs), 200'(0));

    // Reset after 7 beats of a 4x4 load
    @(negedge clk);
    start = 1'b1; matrix_size = 2'b10;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = 8'(i + 1);
    end
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("midrst_mat", matrix_A, '0);
    chk("midrst_ready", 200'(in_ready), 200'(0));
    chk("midrst_busy", 200'(busy), 200'(0));
    chk("midrst_cnt", 200'(elem_count), 200'(0));
    reset = 1'b0;
    vec[0] = 8'h01; vec[1] = 8'h02; vec[2] = 8'h03; vec[3] = 8'h04;
    run_load(2'b00, 4, 1'b0, 1'b0, 200'h04030201, 5, 1'b0);

    // Size shrink: 5x5 with start pokes during LOAD, then 2x2
    for (int i = 0; i < 25; i++) vec[i] = 8'(i + 1);
    run_load(2'b11, 25, 1'b0, 1'b1,
             200'h191817161514131211100F0E0D0C0B0A090807060504030201, 26, 1'b0);
    vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33; vec[3] = 8'h44;
    run_load(2'b00, 4, 1'b0, 1'b0, 200'h44332211, 5, 1'b0);

    // -128 beat, then a clean load that must clear the flag
    vec[0] = 8'h01; vec[1] = 8'h80; vec[2] = 8'h03; vec[3] = 8'h04;
    run_load(2'b00, 4, 1'b0, 1'b0, 200'h04038001, 5, MIN_EXP);
    vec[0] = 8'h05; vec[1] = 8'h06; vec[2] = 8'h07; vec[3] = 8'h08;
    run_load(2'b00, 4, 1'b0, 1'b0, 200'h08070605, 5, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 200'(sb.size()), 200'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
